l2c_write: RTL

- MNI write interface of the L2 cache. It is the write-side counterpart of the L2C read path.
- Accepts a full-line (64 B) burst write from the MNI and performs a tag lookup. On a tag hit it streams the burst beats into the data SRAM of the hit way, sets the line's dirty bit, then broadcasts completion so waiting readers and writers can retry.
- A tag miss is NACKed; there is no write-allocate.
- Sits between the MNI write port, the tag pipeline and the data-SRAM arbiter.

---
 rtl/l2c_pkg.sv | 42 ++++
 rtl/l2c_beat_cnt.sv | 28 ++
 rtl/l2c_write.sv | 113 +++++++++++
 3 files changed

// File: rtl/l2c_pkg.sv
// rtl/l2c_pkg.sv - shared state encoding, address field widths and output flags for the L2C write path
package l2c_pkg;

  localparam int SET_W      = 9;
  localparam int WAY_W      = 3;
  localparam int LINE_BYTES = 64;
  localparam int LINE_OFF_W = $clog2(LINE_BYTES);
  localparam int SET_LSB    = LINE_OFF_W;
  localparam int SRAM_ADR_W = SET_W + WAY_W + LINE_OFF_W;

  typedef enum logic [6:0] {
    WR_IDLE   = 7'b000_0001,
    WR_TAGS   = 7'b000_0010,
    WR_RETRY  = 7'b000_0100,
    WR_GRANT  = 7'b000_1000,
    WR_WRITE  = 7'b001_0000,
    WR_UNLOCK = 7'b010_0000,
    WR_NACK   = 7'b100_0000
  } wr_state_e;

  typedef struct packed {
    logic idle;
    logic tag_req;
    logic stall;
    logic nack;
    logic dirty_set;
    logic broadcast;
  } wr_flags_t;

  // Registered strobes are a pure function of the state being entered.
  function automatic wr_flags_t wr_flags(input wr_state_e s);
    wr_flags_t f;
    f.idle      = (s == WR_IDLE);
    f.tag_req   = (s == WR_TAGS);
    f.stall     = !((s == WR_WRITE) || (s == WR_NACK));
    f.nack      = (s == WR_NACK);
    f.dirty_set = (s == WR_UNLOCK);
    f.broadcast = (s == WR_UNLOCK);
    return f;
  endfunction

endpackage

// File: rtl/l2c_beat_cnt.sv
// rtl/l2c_beat_cnt.sv - beat index counter with synchronous clear, enable and last-beat flag
module l2c_beat_cnt
  import l2c_pkg::*;
#(
  parameter int BEAT_W = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              clear,
  input  logic              enable,
  output logic [BEAT_W-1:0] beat,
  output logic              last
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      beat <= '0;
    end else if (clear) begin
      beat <= '0;
    end else if (enable) begin
      beat <= beat + 1'b1;
    end
  end

  // Accepting the last beat wraps the counter back to 0 on its own.
  assign last = &beat;

endmodule

// File: rtl/l2c_write.sv
// rtl/l2c_write.sv - MNI full-line write port: tag lookup, SRAM burst write on hit, NACK on miss
module l2c_write
  import l2c_pkg::*;
#(
  parameter int DW     = 128,
  parameter int BEAT_W = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  i_maintenance_active,
  input  logic [31:0]           i_mni_write_adr,
  input  logic                  i_mni_write_valid,
  input  logic [DW-1:0]         i_mni_write_data,
  input  logic [DW/8-1:0]       i_mni_write_be,
  input  logic                  i_hit,
  input  logic                  i_miss,
  input  logic                  i_retry,
  input  logic [2:0]            i_way,
  input  logic                  i_wb_ack_broadcast,
  input  logic                  i_fill_broadcast,
  input  logic                  i_read_unlock_broadcast,
  input  logic                  i_sram_grant,
  output logic                  o_write_idle,
  output logic                  o_tag_req,
  output logic                  o_dirty_set,
  output logic [SRAM_ADR_W-1:0] o_sram_adr,
  output logic                  o_sram_we,
  output logic [DW-1:0]         o_sram_wdata,
  output logic [DW/8-1:0]       o_sram_be,
  output logic                  o_mni_write_stall,
  output logic                  o_mni_write_nack,
  output logic                  o_write_broadcast
);

  localparam int PAD_W = LINE_OFF_W - BEAT_W;

  wr_state_e         state;
  wr_state_e         state_nxt;
  wr_flags_t         flags;
  logic [SET_W-1:0]  set_q;
  logic [WAY_W-1:0]  way_q;
  logic [BEAT_W-1:0] beat;
  logic              beat_last;
  logic              beat_accept;
  logic              any_unlock;
  logic              unused_adr;

  assign beat_accept = (state == WR_WRITE) && i_mni_write_valid;
  assign any_unlock  = i_wb_ack_broadcast | i_fill_broadcast | i_read_unlock_broadcast;
  assign unused_adr  = ^{i_mni_write_adr[31:SET_LSB+SET_W], i_mni_write_adr[SET_LSB-1:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      WR_IDLE:   if (i_mni_write_valid && !i_maintenance_active) state_nxt = WR_TAGS;
      WR_TAGS: begin
        if (i_hit)        state_nxt = WR_GRANT;
        else if (i_miss)  state_nxt = WR_NACK;
        else if (i_retry) state_nxt = WR_RETRY;
      end
      WR_RETRY:  if (any_unlock) state_nxt = WR_TAGS;
      WR_GRANT:  if (i_sram_grant) state_nxt = WR_WRITE;
      // The arbiter keeps the grant up for the whole burst, so it is not rechecked here.
      WR_WRITE:  if (beat_accept && beat_last) state_nxt = WR_UNLOCK;
      WR_UNLOCK: state_nxt = WR_IDLE;
      WR_NACK:   state_nxt = WR_IDLE;
      default:   state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= WR_IDLE;
      flags <= wr_flags(WR_IDLE);
    end else begin
      state <= state_nxt;
      flags <= wr_flags(state_nxt);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      set_q <= '0;
      way_q <= '0;
    end else begin
      if ((state == WR_IDLE) && (state_nxt == WR_TAGS)) set_q <= i_mni_write_adr[SET_LSB +: SET_W];
      if ((state == WR_TAGS) && (i_hit || i_miss)) way_q <= i_way;
    end
  end

  l2c_beat_cnt #(
    .BEAT_W(BEAT_W)
  ) u_beat_cnt (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .clear  (state == WR_GRANT),
    .enable (beat_accept),
    .beat   (beat),
    .last   (beat_last)
  );

  assign o_sram_adr        = {set_q, way_q, beat, {PAD_W{1'b0}}};
  assign o_sram_we         = beat_accept;
  assign o_sram_wdata      = i_mni_write_data;
  assign o_sram_be         = i_mni_write_be;
  assign o_write_idle      = flags.idle;
  assign o_tag_req         = flags.tag_req;
  assign o_mni_write_stall = flags.stall;
  assign o_mni_write_nack  = flags.nack;
  assign o_dirty_set       = flags.dirty_set;
  assign o_write_broadcast = flags.broadcast;

endmodule
